// File: rtl/rgen_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgen_apb_pkg
// Description : Shared types and constants for the rgen APB initiator: FSM
//               states, command/response bundles, PPROT bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package rgen_apb_pkg;

  // Storage widths for the command/response bundles; the initiator
  // zero-extends its parameterised fields into these.
  localparam int RGEN_APB_MAX_ADDR_W = 64;
  localparam int RGEN_APB_MAX_DATA_W = 32;
  localparam int RGEN_APB_MAX_STRB_W = RGEN_APB_MAX_DATA_W / 8;

  // PPROT bit meanings.
  localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
  localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
  localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_RESPONSE = 2'd3
  } rgen_apb_state_e;

  typedef struct packed {
    logic                           write;
    logic [RGEN_APB_MAX_ADDR_W-1:0] address;
    logic [RGEN_APB_MAX_DATA_W-1:0] data;
    logic [RGEN_APB_MAX_STRB_W-1:0] strobe;
    logic [2:0]                     prot;
  } rgen_apb_cmd_t;

  typedef struct packed {
    logic [RGEN_APB_MAX_DATA_W-1:0] read_data;
    logic                           slverr;
    logic                           timeout;
  } rgen_apb_rsp_t;

  // Number of low address bits that select a byte within one data word.
  function automatic int rgen_apb_align_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgen_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : rgen_wait_counter
// Description : Counts wait cycles and flags when the LIMIT-th counted cycle
//               is in progress. Saturates at LIMIT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rgen_wait_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CNT_WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(LIMIT - 1);

  logic [CNT_WIDTH-1:0] r_count;

  // Count completed wait cycles; clear has priority so a new transfer starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && (r_count != c_last)) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  // High during the LIMIT-th wait cycle: if it ends without ready, time out.
  assign o_expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/rgen_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : rgen_apb_initiator
// Description : APB4 requester. Accepts one register command at a time,
//               runs the SETUP/ACCESS phases, and returns read data and
//               error/timeout status through a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module rgen_apb_initiator #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_command_valid,
  output logic                      o_command_ready,
  input  logic                      i_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_address,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  input  logic [DATA_WIDTH/8-1:0]   i_strobe,
  input  logic [2:0]                i_prot,
  output logic                      o_response_valid,
  input  logic                      i_response_ready,
  output logic [DATA_WIDTH-1:0]     o_read_data,
  output logic                      o_slverr,
  output logic                      o_timeout,
  output logic [ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [2:0]                o_pprot,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [DATA_WIDTH/8-1:0]   o_pstrb,
  input  logic                      i_pready,
  input  logic [DATA_WIDTH-1:0]     i_prdata,
  input  logic                      i_pslverr
);

  import rgen_apb_pkg::*;

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ALIGN_BITS = rgen_apb_align_bits(DATA_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] c_align_mask = ~ADDRESS_WIDTH'((2 ** ALIGN_BITS) - 1);

  rgen_apb_state_e r_state;
  rgen_apb_state_e w_state_next;
  rgen_apb_cmd_t   r_cmd;
  rgen_apb_rsp_t   r_rsp;
  logic            r_ready_en;

  logic w_accept;
  logic w_capture;
  logic w_timeout_hit;
  logic w_rsp_done;
  logic w_cnt_clear;
  logic w_cnt_count;
  logic w_expired;
  logic w_psel;
  logic w_penable;
  logic w_rsp_valid;
  logic w_unused_bits;

  // State register; r_ready_en keeps command_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
    end
  end

  // Next-state and APB phase control.
  always_comb begin
    w_state_next  = r_state;
    w_psel        = 1'b0;
    w_penable     = 1'b0;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    w_rsp_done    = 1'b0;
    w_cnt_clear   = 1'b0;
    w_cnt_count   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_command_valid && r_ready_en) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_psel       = 1'b1;
        w_cnt_clear  = 1'b1;
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (i_pready) begin
          w_capture    = 1'b1;
          w_state_next = ST_RESPONSE;
        end else begin
          w_cnt_count = 1'b1;
          if (w_expired) begin
            w_timeout_hit = 1'b1;
            w_state_next  = ST_RESPONSE;
          end
        end
      end
      ST_RESPONSE: begin
        if (i_response_ready) begin
          w_rsp_done   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Latch the command; read transfers carry zero data and strobes onto the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
    end else if (w_accept) begin
      r_cmd.write   <= i_write;
      r_cmd.address <= RGEN_APB_MAX_ADDR_W'(i_address & c_align_mask);
      r_cmd.data    <= i_write ? RGEN_APB_MAX_DATA_W'(i_write_data) : '0;
      r_cmd.strobe  <= i_write ? RGEN_APB_MAX_STRB_W'(i_strobe) : '0;
      r_cmd.prot    <= i_prot;
    end
  end

  // Capture completion status; PRDATA is only meaningful for reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp <= '0;
    end else if (w_capture) begin
      r_rsp.read_data <= r_cmd.write ? '0 : RGEN_APB_MAX_DATA_W'(i_prdata);
      r_rsp.slverr    <= i_pslverr;
      r_rsp.timeout   <= 1'b0;
    end else if (w_timeout_hit) begin
      r_rsp.read_data <= '0;
      r_rsp.slverr    <= 1'b1;
      r_rsp.timeout   <= 1'b1;
    end else if (w_rsp_done) begin
      r_rsp <= '0;
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    rgen_wait_counter #(
      .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_cnt_clear),
      .i_count   (w_cnt_count),
      .o_expired (w_expired)
    );
  end else begin : g_no_timeout
    logic w_unused_cnt;
    assign w_expired    = 1'b0;
    assign w_unused_cnt = w_cnt_clear ^ w_cnt_count;
  end

  // Bundle storage is wider than the configured bus; the extra bits stay zero.
  assign w_unused_bits = ^{r_cmd.address, r_cmd.data, r_cmd.strobe, r_rsp.read_data};

  assign w_rsp_valid      = (r_state == ST_RESPONSE);
  assign o_command_ready  = (r_state == ST_IDLE) && r_ready_en;
  assign o_response_valid = w_rsp_valid;
  assign o_read_data      = w_rsp_valid ? r_rsp.read_data[DATA_WIDTH-1:0] : '0;
  assign o_slverr         = w_rsp_valid & r_rsp.slverr;
  assign o_timeout        = w_rsp_valid & r_rsp.timeout;

  assign o_psel    = w_psel;
  assign o_penable = w_penable;
  assign o_paddr   = r_cmd.address[ADDRESS_WIDTH-1:0];
  assign o_pwrite  = r_cmd.write;
  assign o_pwdata  = r_cmd.data[DATA_WIDTH-1:0];
  assign o_pstrb   = r_cmd.strobe[STRB_WIDTH-1:0];
  assign o_pprot   = r_cmd.prot;

endmodule
`default_nettype wire

// File: tb/tb_rgen_apb_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rgen_apb_initiator
// Description : Self-checking bench for rgen_apb_initiator with a 4-cycle
//               access timeout and a behavioural completer/response model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgen_apb_initiator;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_command_valid = 1'b0;
  logic          i_write = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_write_data = '0;
  logic [SW-1:0] i_strobe = '0;
  logic [2:0]    i_prot = '0;
  logic          i_response_ready = 1'b0;
  logic          i_pready = 1'b0;
  logic [DW-1:0] i_prdata = '0;
  logic          i_pslverr = 1'b0;

  logic          o_command_ready, o_response_valid, o_slverr, o_timeout;
  logic [DW-1:0] o_read_data, o_pwdata;
  logic [AW-1:0] o_paddr;
  logic [2:0]    o_pprot;
  logic          o_psel, o_penable, o_pwrite;
  logic [SW-1:0] o_pstrb;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int accept_cycle = 0;

  rgen_apb_initiator #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_command_valid  (i_command_valid),
    .o_command_ready  (o_command_ready),
    .i_write          (i_write),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_strobe         (i_strobe),
    .i_prot           (i_prot),
    .o_response_valid (o_response_valid),
    .i_response_ready (i_response_ready),
    .o_read_data      (o_read_data),
    .o_slverr         (o_slverr),
    .o_timeout        (o_timeout),
    .o_paddr          (o_paddr),
    .o_pprot          (o_pprot),
    .o_psel           (o_psel),
    .o_penable        (o_penable),
    .o_pwrite         (o_pwrite),
    .o_pwdata         (o_pwdata),
    .o_pstrb          (o_pstrb),
    .i_pready         (i_pready),
    .i_prdata         (i_prdata),
    .i_pslverr        (i_pslverr)
  );

  wire [93:0] all_outs = {o_command_ready, o_response_valid, o_read_data, o_slverr, o_timeout,
                          o_paddr, o_pprot, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb};

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete command: the completer raises PREADY after 'waits' low cycles
  // (never, if waits >= TMO); the response is held unconsumed for 'hold' cycles.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                          input logic [DW-1:0] rdata, input logic err, input int hold,
                          input bit noise, input bit keep_valid);
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata, e_rdata;
    logic [SW-1:0] e_pstrb;
    logic          e_slverr, e_tmo;
    int            n_access, guard;
    e_paddr  = addr - AW'(addr % SW);
    e_pwdata = wr ? data : '0;
    e_pstrb  = wr ? strb : '0;
    e_tmo    = (waits >= TMO);
    n_access = e_tmo ? TMO : waits + 1;
    e_slverr = e_tmo ? 1'b1 : err;
    e_rdata  = (e_tmo || wr) ? '0 : rdata;

    guard = 0;
    while (o_command_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (o_command_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: got %b expected 1", o_command_ready);
    end

    i_command_valid  = 1'b1;
    i_write          = wr;
    i_address        = addr;
    i_write_data     = data;
    i_strobe         = strb;
    i_prot           = prot;
    i_response_ready = (hold == 0);
    tick();
    accept_cycle = cycle;
    if (!keep_valid) i_command_valid = 1'b0;

    checks++;
    if ({o_psel, o_penable, o_command_ready, o_response_valid, o_pwrite, o_pprot, o_pstrb, o_paddr, o_pwdata} !==
        {1'b1, 1'b0, 1'b0, 1'b0, wr, prot, e_pstrb, e_paddr, e_pwdata}) begin
      errors++;
      $display("FAIL setup_phase: got sel=%b en=%b rdy=%b wr=%b prot=%h strb=%h addr=%h wd=%h expected sel=1 en=0 rdy=0 wr=%b prot=%h strb=%h addr=%h wd=%h",
               o_psel, o_penable, o_command_ready, o_pwrite, o_pprot, o_pstrb, o_paddr, o_pwdata,
               wr, prot, e_pstrb, e_paddr, e_pwdata);
    end

    for (int k = 0; k < n_access; k++) begin
      tick();
      checks++;
      if ({o_psel, o_penable, o_command_ready, o_response_valid, o_pwrite, o_pprot, o_pstrb, o_paddr, o_pwdata} !==
          {1'b1, 1'b1, 1'b0, 1'b0, wr, prot, e_pstrb, e_paddr, e_pwdata}) begin
        errors++;
        $display("FAIL access_phase[%0d]: got sel=%b en=%b vld=%b addr=%h wd=%h strb=%h expected sel=1 en=1 vld=0 addr=%h wd=%h strb=%h",
                 k, o_psel, o_penable, o_response_valid, o_paddr, o_pwdata, o_pstrb, e_paddr, e_pwdata, e_pstrb);
      end
      if (k == waits) begin
        i_pready  = 1'b1;
        i_prdata  = rdata;
        i_pslverr = err;
      end else begin
        i_pready  = 1'b0;
        i_prdata  = DW'($urandom);
        i_pslverr = noise ? 1'b1 : 1'($urandom);
      end
    end

    tick();
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    i_prdata  = DW'($urandom);
    checks++;
    if ({o_psel, o_penable, o_response_valid, o_command_ready, o_slverr, o_timeout, o_read_data} !==
        {1'b0, 1'b0, 1'b1, 1'b0, e_slverr, e_tmo, e_rdata}) begin
      errors++;
      $display("FAIL response: got sel=%b en=%b vld=%b rdy=%b err=%b tmo=%b rd=%h expected sel=0 en=0 vld=1 rdy=0 err=%b tmo=%b rd=%h",
               o_psel, o_penable, o_response_valid, o_command_ready, o_slverr, o_timeout, o_read_data,
               e_slverr, e_tmo, e_rdata);
    end

    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if ({o_psel, o_response_valid, o_command_ready, o_slverr, o_timeout, o_read_data} !==
          {1'b0, 1'b1, 1'b0, e_slverr, e_tmo, e_rdata}) begin
        errors++;
        $display("FAIL response_hold[%0d]: got sel=%b vld=%b rdy=%b err=%b tmo=%b rd=%h expected sel=0 vld=1 rdy=0 err=%b tmo=%b rd=%h",
                 h, o_psel, o_response_valid, o_command_ready, o_slverr, o_timeout, o_read_data,
                 e_slverr, e_tmo, e_rdata);
      end
    end

    i_response_ready = 1'b1;
    tick();
    i_command_valid = 1'b0;
    checks++;
    if ({o_response_valid, o_slverr, o_timeout, o_read_data, o_command_ready, o_psel} !==
        {1'b0, 1'b0, 1'b0, {DW{1'b0}}, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL after_handshake: got vld=%b err=%b tmo=%b rd=%h rdy=%b sel=%b expected vld=0 err=0 tmo=0 rd=0 rdy=1 sel=0",
               o_response_valid, o_slverr, o_timeout, o_read_data, o_command_ready, o_psel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    checks++;
    if (o_command_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b expected 0", o_command_ready);
    end
    tick();
    checks++;
    if ({o_command_ready, o_response_valid, o_psel, o_penable} !== 4'b1000) begin
      errors++;
      $display("FAIL ready_after_release: got %b expected 1000", {o_command_ready, o_response_valid, o_psel, o_penable});
    end
  endtask

  task automatic test_write_zero_wait();
    run_xfer(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_wait_states();
    run_xfer(1'b0, 16'h0008, 32'hFFFF_FFFF, 4'hF, PPROT_BITS(), 3, 32'h1234_5678, 1'b0, 1, 1'b0, 1'b0);
  endtask

  function automatic logic [2:0] PPROT_BITS();
    return 3'b011;
  endfunction

  task automatic test_read_slverr();
    run_xfer(1'b0, 16'h0020, 32'h0, 4'h0, 3'b001, 2, 32'hA5A5_5A5A, 1'b1, 0, 1'b0, 1'b0);
    // PSLVERR high during every wait cycle must not leak into the result.
    run_xfer(1'b0, 16'h0031, 32'h0, 4'h0, 3'b000, 3, 32'h0BAD_F00D, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 16'h0040, 32'h0, 4'h0, 3'b000, 100, 32'h5555_AAAA, 1'b0, 0, 1'b1, 1'b0);
    run_xfer(1'b1, 16'h0044, 32'h0102_0304, 4'h5, 3'b100, 100, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    run_xfer(1'b0, 16'h0048, 32'h0, 4'h0, 3'b000, 1, 32'h7777_1111, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_response_hold();
    run_xfer(1'b0, 16'h0100, 32'h0, 4'h0, 3'b010, 0, 32'h0F0F_F0F0, 1'b0, 5, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int first;
    run_xfer(1'b1, 16'h0200, 32'h1111_2222, 4'h3, 3'b000, 0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    first = accept_cycle;
    run_xfer(1'b0, 16'h0204, 32'h0, 4'h0, 3'b000, 0, 32'h3333_4444, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (accept_cycle - first !== 4) begin
      errors++;
      $display("FAIL back_to_back_spacing: got %0d cycles expected 4", accept_cycle - first);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_xfer(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom), 3'($urandom),
               int'($urandom_range(0, 5)), DW'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset_mid_access();
    i_command_valid = 1'b1;
    i_write         = 1'b1;
    i_address       = 16'h0300;
    i_write_data    = 32'h9999_8888;
    i_strobe        = 4'hF;
    i_prot          = 3'b111;
    i_pready        = 1'b0;
    tick();
    i_command_valid = 1'b0;
    tick();
    checks++;
    if ({o_psel, o_penable} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_access: got %b expected 11", {o_psel, o_penable});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h expected 0", all_outs);
    end
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (o_command_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge_2: got %b expected 0", o_command_ready);
    end
    i_response_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({o_command_ready, o_response_valid, o_psel, o_penable} !== 4'b1000) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: got %b expected 1000", k, {o_command_ready, o_response_valid, o_psel, o_penable});
      end
    end
    run_xfer(1'b0, 16'h0304, 32'h0, 4'h0, 3'b000, 1, 32'hBEEF_0001, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_read_slverr();
    test_timeout();
    test_response_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
